stream_writer: RTL

STREAM_WRITER -- requirements
Module: stream_writer

---
 rtl/stream_writer_pkg.sv | 21 ++
 rtl/stream_writer_if.sv | 14 +
 rtl/mem_entry_fifo.sv | 63 ++++++
 rtl/stream_writer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/stream_writer_pkg.sv
// Shared types and constants for the stream writer and its write queue.
// No logic beyond a lane-mask helper; zero latency, no backpressure.
package stream_writer_pkg;

    localparam int ACC_BYTES  = 16;
    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } mem_entry_t;

    // be[3] is the lowest-addressed lane, so a run starting at lane off shifts right.
    function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [2:0] size);
        logic [3:0] m;
        m = 4'hF << (3'd4 - size);
        return m >> off;
    endfunction

endpackage

// File: rtl/stream_writer_if.sv
// Memory-write handshake bundle between the stream writer and its memory port.
// Valid/ready: the master holds addr/data/byte_en steady until mem_ready is seen.
interface stream_writer_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_byte_en;

    modport master (output mem_valid, output mem_addr, output mem_data, output mem_byte_en,
                    input  mem_ready);
    modport slave  (input  mem_valid, input  mem_addr, input  mem_data, input  mem_byte_en,
                    output mem_ready);
endinterface

// File: rtl/mem_entry_fifo.sv
// Write queue with two write ports and one read port; head visible the cycle after a write.
// Writers must respect free_cnt (plus the same-cycle read); a full queue still accepts a write that coincides with a read.
module mem_entry_fifo
    import stream_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr0_vld,
    input  mem_entry_t               wr0_dat,
    input  logic                     wr1_vld,
    input  mem_entry_t               wr1_dat,
    input  logic                     rd_rdy,
    output mem_entry_t               rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    mem_entry_t    mem_q [DEPTH];
    mem_entry_t    mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd_fire;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign free_cnt = CW'(DEPTH) - cnt_q;
    assign rd_fire  = rd_rdy && !empty;
    assign rd_dat   = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        if (wr0_vld) begin
            mem_d[wptr_q] = wr0_dat;
            wptr_d        = wptr_q + AW'(1);
        end
        if (wr1_vld) begin
            mem_d[wptr_q + AW'(1)] = wr1_dat;
            wptr_d                 = wptr_q + AW'(2);
        end
        rptr_d = rd_fire ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q + CW'(wr0_vld) + CW'(wr1_vld) - CW'(rd_fire);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/stream_writer.sv
// Packs a byte stream into 32-bit memory words and merges byte patches into the same write queue.
// Words appear on mem_* one cycle after completion; in_ready drops when the accumulator or queue is near full.
module stream_writer
    import stream_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [3:0]      in_byte_count,
    input  logic [63:0]     in_val,
    output logic            in_ready,
    input  logic            flush,
    input  logic            patch_enable,
    input  logic [31:0]     patch_addr,
    input  logic [31:0]     patch_val,
    input  logic [31:0]     patch_byte_size,
    output logic [31:0]     total_bytes,
    output logic            error,
    stream_writer_if.master mem_if
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int AB = ACC_BYTES * 8;
    localparam int WB = WORD_BYTES * 8;

    logic [AB-1:0] acc_q, acc_d, acc_app;
    logic [4:0]    acc_cnt_q, acc_cnt_d, cnt_app, cnt_pad;
    logic [31:0]   total_bytes_q, total_bytes_d, word_addr_q, word_addr_d;
    logic          error_q, error_d, ready_en_q, ready_en_d, pend_vld_q, pend_vld_d;
    mem_entry_t    pend_q, pend_d, patch_ent, word0, word1, wr0_dat, wr1_dat, rd_dat;
    logic          accept, bad_in, patch_ok, pend_go, patch_direct, wr0_vld, wr1_vld;
    logic          fifo_full, fifo_empty, deq;
    logic [63:0]   in_masked;
    logic [2:0]    pad, avail, psize, shift;
    logic [1:0]    nwords, off;
    logic [3:0]    pbe;
    logic [AW:0]   free_cnt;
    logic [AW+1:0] space;

    assign in_ready = ready_en_q && !fifo_full && (acc_cnt_q <= 5'd8) && (free_cnt >= (AW+1)'(2));
    assign accept   = in_ready && (in_byte_count != 4'd0) && (in_byte_count <= 4'd8);
    assign bad_in   = (in_byte_count != 4'd0) && !accept;
    assign deq      = !fifo_empty && mem_if.mem_ready;
    assign space    = {1'b0, free_cnt} + {{(AW+1){1'b0}}, deq};

    always_comb begin
        in_masked = in_val & ~(64'hFFFF_FFFF_FFFF_FFFF >> {in_byte_count, 3'b000});
        acc_app   = acc_q;
        cnt_app   = acc_cnt_q;
        if (accept) begin
            acc_app = acc_q | ({in_masked, 64'h0} >> {acc_cnt_q, 3'b000});
            cnt_app = acc_cnt_q + {1'b0, in_byte_count};
        end
        // Bytes past the occupancy are always zero, so padding only bumps the count.
        pad     = (flush && cnt_app[1:0] != 2'd0) ? 3'd4 - {1'b0, cnt_app[1:0]} : 3'd0;
        cnt_pad = cnt_app + {2'b00, pad};
        avail   = cnt_pad[4:2];

        nwords = 2'd0;
        if (avail >= 3'd2 && space >= (AW+2)'(2)) nwords = 2'd2;
        else if (avail != 3'd0 && space != '0)    nwords = 2'd1;

        off            = patch_addr[1:0];
        psize          = patch_byte_size[2:0];
        patch_ok       = (patch_byte_size != 32'd0) && (patch_byte_size <= 32'd4) &&
                         (({1'b0, off} + psize) <= 3'd4);
        pbe            = lane_mask(off, psize);
        shift          = 3'd4 - {1'b0, off} - psize;
        patch_ent.addr = {patch_addr[31:2], 2'b00};
        patch_ent.data = (patch_val << {shift, 3'b000}) &
                         {{8{pbe[3]}}, {8{pbe[2]}}, {8{pbe[1]}}, {8{pbe[0]}}};
        patch_ent.be   = pbe;

        // Stream words always take the lower write ports; patches fill what is left.
        pend_go      = pend_vld_q && (nwords != 2'd2) && (space > (AW+2)'(nwords));
        patch_direct = patch_enable && patch_ok && !pend_vld_q && (nwords == 2'd0) && (space != '0);

        word0.addr = word_addr_q;
        word0.data = acc_app[AB-1 -: WB];
        word0.be   = 4'hF;
        word1.addr = word_addr_q + 32'd4;
        word1.data = acc_app[AB-WB-1 -: WB];
        word1.be   = 4'hF;

        wr0_vld = (nwords != 2'd0) || pend_go || patch_direct;
        wr0_dat = (nwords != 2'd0) ? word0 : (pend_go ? pend_q : patch_ent);
        wr1_vld = (nwords == 2'd2) || ((nwords == 2'd1) && pend_go);
        wr1_dat = (nwords == 2'd2) ? word1 : pend_q;

        acc_d         = acc_app << {nwords, 5'b00000};
        acc_cnt_d     = cnt_pad - {1'b0, nwords, 2'b00};
        word_addr_d   = word_addr_q + {28'd0, nwords, 2'b00};
        total_bytes_d = total_bytes_q + (accept ? {28'd0, in_byte_count} : 32'd0) + {29'd0, pad};
        ready_en_d    = 1'b1;

        pend_vld_d = pend_vld_q && !pend_go;
        pend_d     = pend_q;
        if (patch_enable && patch_ok && !pend_vld_q && !patch_direct) begin
            pend_vld_d = 1'b1;
            pend_d     = patch_ent;
        end
        error_d = error_q || bad_in || (patch_enable && (!patch_ok || pend_vld_q));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q         <= '0;
            acc_cnt_q     <= '0;
            total_bytes_q <= '0;
            word_addr_q   <= '0;
            error_q       <= 1'b0;
            ready_en_q    <= 1'b0;
            pend_vld_q    <= 1'b0;
            pend_q        <= '0;
        end else begin
            acc_q         <= acc_d;
            acc_cnt_q     <= acc_cnt_d;
            total_bytes_q <= total_bytes_d;
            word_addr_q   <= word_addr_d;
            error_q       <= error_d;
            ready_en_q    <= ready_en_d;
            pend_vld_q    <= pend_vld_d;
            pend_q        <= pend_d;
        end
    end

    mem_entry_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr0_vld  (wr0_vld),
        .wr0_dat  (wr0_dat),
        .wr1_vld  (wr1_vld),
        .wr1_dat  (wr1_dat),
        .rd_rdy   (mem_if.mem_ready),
        .rd_dat   (rd_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .free_cnt (free_cnt)
    );

    assign mem_if.mem_valid   = !fifo_empty;
    assign mem_if.mem_addr    = rd_dat.addr;
    assign mem_if.mem_data    = rd_dat.data;
    assign mem_if.mem_byte_en = rd_dat.be;
    assign total_bytes        = total_bytes_q;
    assign error              = error_q;
endmodule
